// File: rtl/vram_snoop_feeder.sv
// rtl/vram_snoop_feeder.sv - captures CPU writes to the video window and replays them on the VRAM snoop port
// Optional tail-entry write merging is enabled by defining VRAM_SNOOP_MERGE_EN.
module vram_snoop_feeder #(
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   WIN_TAG_W  = 2,
  parameter logic [WIN_TAG_W-1:0] WIN_TAG    = 2'b11
) (
  input  logic                            clk42_i,
  input  logic                            res_i,
  input  logic                            cmd_valid_i,
  input  logic                            cmd_we_i,
  input  logic [19:0]                     cmd_addr_i,
  input  logic [15:0]                     cmd_data_i,
  input  logic [1:0]                      cmd_be_i,
  input  logic                            slot_i,
  input  logic                            ovf_clr_i,
  output logic [19:0]                     vaddr_o,
  output logic [15:0]                     md_o,
  output logic                            wr_o,
  output logic                            double_cas_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [18:0]   r_mem_addr [FIFO_DEPTH];
  logic [15:0]   r_mem_data [FIFO_DEPTH];
  logic [1:0]    r_mem_be   [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_count;
  logic [19:0]   r_vaddr;
  logic [15:0]   r_md;
  logic          r_wr;
  logic          r_dcas;
  logic          r_ovf;

  logic          w_cap;
  logic          w_pop;
  logic          w_full;
  logic          w_merge;
  logic          w_push;
  logic          w_ovf;
  logic [18:0]   w_head_addr;
  logic [15:0]   w_head_data;
  logic [1:0]    w_head_be;
  logic          w_unused_addr0;

  assign w_unused_addr0 = cmd_addr_i[0];

  assign w_cap  = cmd_valid_i & cmd_we_i & (|cmd_be_i) &
                  (cmd_addr_i[19:20-WIN_TAG_W] == WIN_TAG);
  assign w_pop  = slot_i & (r_count != '0);
  assign w_full = (r_count == LW'(FIFO_DEPTH));

`ifdef VRAM_SNOOP_MERGE_EN
  logic [AW-1:0] w_tail;
  assign w_tail  = r_wptr - AW'(1);
  // With a single entry the tail is also the head; merging into an entry being popped would lose the data.
  assign w_merge = w_cap & (r_count != '0) & ~(w_pop & (r_count == LW'(1))) &
                   (r_mem_addr[w_tail] == cmd_addr_i[19:1]);
`else
  assign w_merge = 1'b0;
`endif

  assign w_push = w_cap & ~w_merge & (~w_full | w_pop);
  assign w_ovf  = w_cap & ~w_merge & w_full & ~w_pop;

  assign w_head_addr = r_mem_addr[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];
  assign w_head_be   = r_mem_be[r_rptr];

  always_ff @(posedge clk42_i) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= cmd_addr_i[19:1];
      r_mem_data[r_wptr] <= cmd_data_i;
      r_mem_be[r_wptr]   <= cmd_be_i;
    end
`ifdef VRAM_SNOOP_MERGE_EN
    if (w_merge) begin
      r_mem_be[w_tail] <= r_mem_be[w_tail] | cmd_be_i;
      if (cmd_be_i[0]) r_mem_data[w_tail][7:0]  <= cmd_data_i[7:0];
      if (cmd_be_i[1]) r_mem_data[w_tail][15:8] <= cmd_data_i[15:8];
    end
`endif
  end

  always_ff @(posedge clk42_i) begin
    if (res_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vaddr <= '0;
      r_md    <= '0;
      r_wr    <= 1'b0;
      r_dcas  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + LW'(w_push) - LW'(w_pop);
      r_wr    <= w_pop;
      if (w_pop) begin
        // Single-byte writes always present the byte on md[7:0] with the exact byte address.
        case (w_head_be)
          2'b10: begin
            r_vaddr <= {w_head_addr, 1'b1};
            r_md    <= {8'h00, w_head_data[15:8]};
            r_dcas  <= 1'b0;
          end
          2'b01: begin
            r_vaddr <= {w_head_addr, 1'b0};
            r_md    <= {8'h00, w_head_data[7:0]};
            r_dcas  <= 1'b0;
          end
          default: begin
            r_vaddr <= {w_head_addr, 1'b0};
            r_md    <= w_head_data;
            r_dcas  <= 1'b1;
          end
        endcase
      end
      if (w_ovf)          r_ovf <= 1'b1;
      else if (ovf_clr_i) r_ovf <= 1'b0;
    end
  end

  assign vaddr_o      = r_vaddr;
  assign md_o         = r_md;
  assign wr_o         = r_wr;
  assign double_cas_o = r_dcas;
  assign fifo_level_o = r_count;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_vram_snoop_feeder.sv
// tb/tb_vram_snoop_feeder.sv - self-checking bench for vram_snoop_feeder
module tb_vram_snoop_feeder;
  localparam int DEPTH = 8;

  logic        clk42_i = 1'b0;
  logic        res_i, cmd_valid_i, cmd_we_i, slot_i, ovf_clr_i;
  logic [19:0] cmd_addr_i;
  logic [15:0] cmd_data_i;
  logic [1:0]  cmd_be_i;
  logic [19:0] vaddr_o;
  logic [15:0] md_o;
  logic        wr_o, double_cas_o, overflow_o;
  logic [3:0]  fifo_level_o;

  int total = 0;
  int bad   = 0;

  always #5 clk42_i = ~clk42_i;

  vram_snoop_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk42_i(clk42_i), .res_i(res_i), .cmd_valid_i(cmd_valid_i), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_be_i(cmd_be_i),
    .slot_i(slot_i), .ovf_clr_i(ovf_clr_i), .vaddr_o(vaddr_o), .md_o(md_o),
    .wr_o(wr_o), .double_cas_o(double_cas_o), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o)
  );

  typedef struct {
    logic valid, we; logic [19:0] addr; logic [15:0] data; logic [1:0] be; logic slot;
    logic wr; logic [19:0] vaddr; logic [15:0] md; logic dc; logic [3:0] level;
  } vec_t;

  typedef struct packed { logic [18:0] a; logic [15:0] d; logic [1:0] be; } ent_t;

  ent_t        mq[$];
  logic        m_wr, m_dc, m_ovf;
  logic [19:0] m_vaddr;
  logic [15:0] m_md;
  bit          model_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [19:0] a,
                       input logic [15:0] d, input logic [1:0] be, input logic slot);
    cmd_valid_i = v; cmd_we_i = we; cmd_addr_i = a; cmd_data_i = d; cmd_be_i = be; slot_i = slot;
  endtask

  task automatic model_reset();
    mq.delete();
    m_wr = 0; m_dc = 0; m_ovf = 0; m_vaddr = '0; m_md = '0;
  endtask

  // Reference: a queue of pending writes evaluated once per clock edge.
  task automatic model_step();
    int   n;
    bit   pop, cap, merged, set;
    ent_t e;
    if (res_i) begin
      model_reset();
      return;
    end
    n = mq.size();
    pop = slot_i && (n != 0);
    set = 0;
    m_wr = pop;
    if (pop) begin
      e = mq.pop_front();
      if (e.be == 2'b11) begin m_vaddr = {e.a, 1'b0}; m_md = e.d; m_dc = 1; end
      else if (e.be == 2'b01) begin m_vaddr = {e.a, 1'b0}; m_md = {8'h00, e.d[7:0]}; m_dc = 0; end
      else begin m_vaddr = {e.a, 1'b1}; m_md = {8'h00, e.d[15:8]}; m_dc = 0; end
    end
    cap = cmd_valid_i && cmd_we_i && (cmd_be_i != 2'b00) && (cmd_addr_i[19:18] == 2'b11);
    if (cap) begin
      merged = 0;
`ifdef VRAM_SNOOP_MERGE_EN
      if (n != 0 && !(pop && n == 1) && mq[mq.size()-1].a == cmd_addr_i[19:1]) begin
        e = mq[mq.size()-1];
        if (cmd_be_i[0]) e.d[7:0]  = cmd_data_i[7:0];
        if (cmd_be_i[1]) e.d[15:8] = cmd_data_i[15:8];
        e.be = e.be | cmd_be_i;
        mq[mq.size()-1] = e;
        merged = 1;
      end
`endif
      if (!merged) begin
        if (n < DEPTH || pop) mq.push_back('{a: cmd_addr_i[19:1], d: cmd_data_i, be: cmd_be_i});
        else set = 1;
      end
    end
    if (set) m_ovf = 1;
    else if (ovf_clr_i) m_ovf = 0;
  endtask

  task automatic tick();
    @(posedge clk42_i);
    if (model_on) model_step();
    #1;
    if (model_on) begin
      chk("rnd_wr", 32'(wr_o), 32'(m_wr));
      chk("rnd_level", 32'(fifo_level_o), 32'(mq.size()));
      chk("rnd_ovf", 32'(overflow_o), 32'(m_ovf));
      chk("rnd_vaddr", 32'(vaddr_o), 32'(m_vaddr));
      chk("rnd_md", 32'(md_o), 32'(m_md));
      chk("rnd_dcas", 32'(double_cas_o), 32'(m_dc));
    end
  endtask

  task automatic do_reset();
    res_i = 1; drive(0, 0, '0, '0, 2'b00, 0); ovf_clr_i = 0;
    tick(); tick();
    res_i = 0;
  endtask

  task automatic fill(input logic [19:0] base, input logic [15:0] dbase, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      drive(1, 1, base + 20'(2 * i), dbase + 16'(i), 2'b11, 0);
      tick();
    end
    drive(0, 0, '0, '0, 2'b00, 0);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 20'hF1234, 16'hBEEF, 2'b11, 1'b1, 1'b0, 20'h00000, 16'h0000, 1'b0, 4'd1};
    tbl[1]  = '{1'b0, 1'b0, 20'h00000, 16'h0000, 2'b00, 1'b1, 1'b1, 20'hF1234, 16'hBEEF, 1'b1, 4'd0};
    tbl[2]  = '{1'b1, 1'b1, 20'hC0010, 16'hAB55, 2'b10, 1'b1, 1'b0, 20'hF1234, 16'hBEEF, 1'b1, 4'd1};
    tbl[3]  = '{1'b1, 1'b1, 20'h40010, 16'h1111, 2'b11, 1'b1, 1'b1, 20'hC0011, 16'h00AB, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, 1'b0, 20'h00000, 16'h0000, 2'b00, 1'b1, 1'b0, 20'hC0011, 16'h00AB, 1'b0, 4'd0};
    tbl[5]  = '{1'b1, 1'b0, 20'hC0000, 16'h5555, 2'b11, 1'b0, 1'b0, 20'hC0011, 16'h00AB, 1'b0, 4'd0};
    tbl[6]  = '{1'b1, 1'b1, 20'hC0000, 16'h5555, 2'b00, 1'b0, 1'b0, 20'hC0011, 16'h00AB, 1'b0, 4'd0};
    tbl[7]  = '{1'b1, 1'b1, 20'hC0022, 16'h12CD, 2'b01, 1'b0, 1'b0, 20'hC0011, 16'h00AB, 1'b0, 4'd1};
    tbl[8]  = '{1'b0, 1'b1, 20'hC0030, 16'h7777, 2'b11, 1'b0, 1'b0, 20'hC0011, 16'h00AB, 1'b0, 4'd1};
    tbl[9]  = '{1'b0, 1'b0, 20'h00000, 16'h0000, 2'b00, 1'b1, 1'b1, 20'hC0022, 16'h00CD, 1'b0, 4'd0};
    tbl[10] = '{1'b0, 1'b0, 20'h00000, 16'h0000, 2'b00, 1'b1, 1'b0, 20'hC0022, 16'h00CD, 1'b0, 4'd0};

    do_reset();
    chk("reset_wr", 32'(wr_o), 0);
    chk("reset_vaddr", 32'(vaddr_o), 0);
    chk("reset_md", 32'(md_o), 0);
    chk("reset_dcas", 32'(double_cas_o), 0);
    chk("reset_level", 32'(fifo_level_o), 0);
    chk("reset_ovf", 32'(overflow_o), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].slot);
      tick();
      chk($sformatf("vec%0d_wr", i), 32'(wr_o), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_vaddr", i), 32'(vaddr_o), 32'(tbl[i].vaddr));
      chk($sformatf("vec%0d_md", i), 32'(md_o), 32'(tbl[i].md));
      chk($sformatf("vec%0d_dcas", i), 32'(double_cas_o), 32'(tbl[i].dc));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level_o), 32'(tbl[i].level));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow_o), 0);
    end

    // Nine writes into an 8-deep FIFO with no slots: ninth dropped, then drain in order.
    do_reset();
    fill(20'hC0100, 16'h1000, 9);
    chk("ovf9_level", 32'(fifo_level_o), 8);
    chk("ovf9_flag", 32'(overflow_o), 1);
    slot_i = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain%0d_wr", i), 32'(wr_o), 1);
      chk($sformatf("drain%0d_vaddr", i), 32'(vaddr_o), 32'(20'hC0100 + 20'(2 * i)));
      chk($sformatf("drain%0d_md", i), 32'(md_o), 32'(16'h1000 + 16'(i)));
    end
    tick();
    chk("drain_end_wr", 32'(wr_o), 0);
    chk("drain_end_level", 32'(fifo_level_o), 0);
    chk("ovf_sticky", 32'(overflow_o), 1);
    ovf_clr_i = 1; tick(); ovf_clr_i = 0;
    chk("ovf_clear", 32'(overflow_o), 0);

    // Full FIFO, write together with a slot: accepted, level unchanged.
    fill(20'hC0200, 16'h2000, 8);
    drive(1, 1, 20'hC0300, 16'h2222, 2'b11, 1);
    tick();
    chk("fullpop_wr", 32'(wr_o), 1);
    chk("fullpop_vaddr", 32'(vaddr_o), 32'(20'hC0200));
    chk("fullpop_level", 32'(fifo_level_o), 8);
    chk("fullpop_ovf", 32'(overflow_o), 0);
    drive(0, 0, '0, '0, 2'b00, 1);
    for (int i = 1; i < 9; i++) begin
      tick();
      chk($sformatf("fp_drain%0d_vaddr", i), 32'(vaddr_o),
          (i < 8) ? 32'(20'hC0200 + 20'(2 * i)) : 32'(20'hC0300));
      chk($sformatf("fp_drain%0d_md", i), 32'(md_o),
          (i < 8) ? 32'(16'h2000 + 16'(i)) : 32'(16'h2222));
    end
    tick();
    chk("fp_end_level", 32'(fifo_level_o), 0);

    // Clear and a new overflow on the same edge: set wins.
    fill(20'hC0400, 16'h4000, 8);
    drive(1, 1, 20'hC0500, 16'h4444, 2'b11, 0);
    ovf_clr_i = 1; tick(); ovf_clr_i = 0;
    chk("clr_vs_set", 32'(overflow_o), 1);
    drive(0, 0, '0, '0, 2'b00, 0);
    ovf_clr_i = 1; tick(); ovf_clr_i = 0;
    chk("clr_after", 32'(overflow_o), 0);

    // Reset with entries pending: nothing stale comes out afterwards.
    do_reset();
    fill(20'hC0600, 16'h6000, 3);
    chk("pre_res_level", 32'(fifo_level_o), 3);
    slot_i = 1; tick();
    res_i = 1; tick(); res_i = 0;
    chk("midres_level", 32'(fifo_level_o), 0);
    chk("midres_wr", 32'(wr_o), 0);
    chk("midres_ovf", 32'(overflow_o), 0);
    chk("midres_vaddr", 32'(vaddr_o), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("postres%0d_wr", i), 32'(wr_o), 0);
    end

`ifdef VRAM_SNOOP_MERGE_EN
    do_reset();
    drive(1, 1, 20'hC0020, 16'h0012, 2'b01, 0); tick();
    drive(1, 1, 20'hC0020, 16'h3400, 2'b10, 0); tick();
    drive(0, 0, '0, '0, 2'b00, 0); tick();
    chk("merge_level", 32'(fifo_level_o), 1);
    slot_i = 1; tick();
    chk("merge_wr", 32'(wr_o), 1);
    chk("merge_md", 32'(md_o), 32'(16'h3412));
    chk("merge_dcas", 32'(double_cas_o), 1);
    chk("merge_vaddr", 32'(vaddr_o), 32'(20'hC0020));
    tick();
    chk("merge_once", 32'(wr_o), 0);
`endif

    // Randomized traffic against the queue model, with slot availability varying by phase.
    do_reset();
    model_reset();
    model_on = 1;
    for (int c = 0; c < 3000; c++) begin
      int ph;
      logic [1:0] tag;
      ph = (c / 200) % 3;
      tag = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
            {tag, 14'h0, 4'($urandom_range(0, 15))}, 16'($urandom), 2'($urandom_range(0, 3)),
            (ph == 0) ? ($urandom_range(0, 7) == 0) : (ph == 1) ? ($urandom_range(0, 3) != 0)
                                                                : ($urandom_range(0, 1) == 0));
      ovf_clr_i = ($urandom_range(0, 15) == 0);
      res_i = ($urandom_range(0, 499) == 0);
      tick();
    end
    model_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
